// File: rtl/obuf_acc_pkg.sv
// Shared widths, stage indices, base-select encoding and sign-extension helpers
// for the output-buffer accumulator.
package obuf_acc_pkg;

  localparam int unsigned ARRAY_M_DEF         = 4;
  localparam int unsigned PE_OUT_WIDTH_DEF    = 32;
  localparam int unsigned ACC_WIDTH_DEF       = 48;
  localparam int unsigned BIAS_WIDTH_DEF      = 32;
  localparam int unsigned OBUF_ADDR_WIDTH_DEF = 16;

  // Pipeline stage indices: accept, add, write, forward-hold
  localparam int unsigned STAGE_S0 = 0;
  localparam int unsigned STAGE_S1 = 1;
  localparam int unsigned STAGE_S2 = 2;
  localparam int unsigned STAGE_S3 = 3;

  typedef logic [PE_OUT_WIDTH_DEF-1:0] psum_t;
  typedef logic [BIAS_WIDTH_DEF-1:0]   bias_t;
  typedef logic [ACC_WIDTH_DEF-1:0]    acc_t;

  // Where a lane takes its accumulation base from
  typedef enum logic [1:0] {
    BASE_FIRST = 2'd0,
    BASE_S2    = 2'd1,
    BASE_S3    = 2'd2,
    BASE_OBUF  = 2'd3
  } base_sel_e;

  function automatic acc_t psum_to_acc(input psum_t p);
    return {{(ACC_WIDTH_DEF - PE_OUT_WIDTH_DEF){p[PE_OUT_WIDTH_DEF-1]}}, p};
  endfunction

  function automatic acc_t bias_to_acc(input bias_t b);
    return {{(ACC_WIDTH_DEF - BIAS_WIDTH_DEF){b[BIAS_WIDTH_DEF-1]}}, b};
  endfunction

endpackage

// File: rtl/obuf_accumulator_if.sv
// Row input, output-buffer read/write and completion signals of the accumulator.
interface obuf_accumulator_if
  import obuf_acc_pkg::*;
#(
  parameter int unsigned ARRAY_M         = ARRAY_M_DEF,
  parameter int unsigned PE_OUT_WIDTH    = PE_OUT_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH       = ACC_WIDTH_DEF,
  parameter int unsigned BIAS_WIDTH      = BIAS_WIDTH_DEF,
  parameter int unsigned OBUF_ADDR_WIDTH = OBUF_ADDR_WIDTH_DEF
);

  logic                            in_valid;
  logic [ARRAY_M*PE_OUT_WIDTH-1:0] in_data;
  logic [OBUF_ADDR_WIDTH-1:0]      in_addr;
  logic                            in_first;
  logic                            in_last;
  logic [ARRAY_M*BIAS_WIDTH-1:0]   bias_data;

  logic                            obuf_read_req;
  logic [OBUF_ADDR_WIDTH-1:0]      obuf_read_addr;
  logic [ARRAY_M*ACC_WIDTH-1:0]    obuf_read_data;

  logic                            obuf_write_req;
  logic [OBUF_ADDR_WIDTH-1:0]      obuf_write_addr;
  logic [ARRAY_M*ACC_WIDTH-1:0]    obuf_write_data;

  logic                            done_valid;
  logic [OBUF_ADDR_WIDTH-1:0]      done_addr;
  logic                            busy;

  // Array side plus output buffer: drives rows and read data
  modport master (
    output in_valid, in_data, in_addr, in_first, in_last, bias_data,
    output obuf_read_data,
    input  obuf_read_req, obuf_read_addr,
    input  obuf_write_req, obuf_write_addr, obuf_write_data,
    input  done_valid, done_addr, busy
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, in_addr, in_first, in_last, bias_data,
    input  obuf_read_data,
    output obuf_read_req, obuf_read_addr,
    output obuf_write_req, obuf_write_addr, obuf_write_data,
    output done_valid, done_addr, busy
  );

endinterface

// File: rtl/acc_lane.sv
// One lane: pick the accumulation base and add the sign-extended partial sum.
module acc_lane
  import obuf_acc_pkg::*;
(
  input  psum_t     psum,
  input  acc_t      first_base,
  input  acc_t      s2_data,
  input  acc_t      s3_data,
  input  acc_t      obuf_data,
  input  base_sel_e sel,
  output acc_t      sum_c
);

  acc_t base_c;

  // Base mux; the select is computed once in the top for all lanes
  always_comb begin
    base_c = obuf_data;
    case (sel)
      BASE_FIRST: base_c = first_base;
      BASE_S2:    base_c = s2_data;
      BASE_S3:    base_c = s3_data;
      default:    base_c = obuf_data;
    endcase
  end

  // Two's-complement wrap, no saturation
  assign sum_c = base_c + psum_to_acc(psum);

endmodule

// File: rtl/obuf_accumulator.sv
// Read-modify-write accumulator behind the systolic array.
// S0 accept/read, S1 base select + add, S2 write registers, S3 forward hold.
// Build option: OBUF_ACC_BIAS_EN adds bias_data on first-pass rows;
// without it the first-pass base is zero and bias_data is ignored.
module obuf_accumulator
  import obuf_acc_pkg::*;
#(
  parameter int unsigned ARRAY_M         = ARRAY_M_DEF,
  parameter int unsigned PE_OUT_WIDTH    = PE_OUT_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH       = ACC_WIDTH_DEF,
  parameter int unsigned BIAS_WIDTH      = BIAS_WIDTH_DEF,
  parameter int unsigned OBUF_ADDR_WIDTH = OBUF_ADDR_WIDTH_DEF
) (
  input logic               clk,
  input logic               reset,
  obuf_accumulator_if.slave bus
);

  localparam int unsigned PSUM_BUS_W = ARRAY_M * PE_OUT_WIDTH;
  localparam int unsigned ACC_BUS_W  = ARRAY_M * ACC_WIDTH;

  logic [STAGE_S3:STAGE_S0+1] vld_q, vld_d;

  logic [OBUF_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic                       s1_first_q, s1_first_d;
  logic                       s1_last_q, s1_last_d;
  logic [PSUM_BUS_W-1:0]      s1_data_q, s1_data_d;

  logic [OBUF_ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
  logic [ACC_BUS_W-1:0]       s2_data_q, s2_data_d;
  logic                       done_q, done_d;

  logic [OBUF_ADDR_WIDTH-1:0] s3_addr_q, s3_addr_d;
  logic [ACC_BUS_W-1:0]       s3_data_q, s3_data_d;

  logic                       busy_q, busy_d;

  base_sel_e                  sel_c;
  logic [ACC_BUS_W-1:0]       sum_c;

  // Read is issued straight from the incoming row
  assign bus.obuf_read_req  = bus.in_valid & ~bus.in_first;
  assign bus.obuf_read_addr = bus.in_addr;

  // Base priority: first pass, then newest in-flight result, then obuf
  always_comb begin
    sel_c = BASE_OBUF;
    if (s1_first_q) begin
      sel_c = BASE_FIRST;
    end else if (vld_q[STAGE_S2] && (s2_addr_q == s1_addr_q)) begin
      sel_c = BASE_S2;
    end else if (vld_q[STAGE_S3] && (s3_addr_q == s1_addr_q)) begin
      sel_c = BASE_S3;
    end
  end

  // Per-lane base mux and adder
  for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
    acc_t first_base;
`ifdef OBUF_ACC_BIAS_EN
    assign first_base = bias_to_acc(bus.bias_data[m*BIAS_WIDTH +: BIAS_WIDTH]);
`else
    assign first_base = '0;
`endif
    acc_lane u_lane (
      .psum       (s1_data_q[m*PE_OUT_WIDTH +: PE_OUT_WIDTH]),
      .first_base (first_base),
      .s2_data    (s2_data_q[m*ACC_WIDTH +: ACC_WIDTH]),
      .s3_data    (s3_data_q[m*ACC_WIDTH +: ACC_WIDTH]),
      .obuf_data  (bus.obuf_read_data[m*ACC_WIDTH +: ACC_WIDTH]),
      .sel        (sel_c),
      .sum_c      (sum_c[m*ACC_WIDTH +: ACC_WIDTH])
    );
  end

`ifndef OBUF_ACC_BIAS_EN
  // Bias port kept for pin compatibility only
  logic unused_bias;
  assign unused_bias = ^bus.bias_data[ARRAY_M*BIAS_WIDTH-1:0];
`endif

  // Next-state for the valid pipeline and stage payloads
  always_comb begin
    vld_d      = '0;
    s1_addr_d  = s1_addr_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_data_d  = s1_data_q;
    s2_addr_d  = s2_addr_q;
    s2_data_d  = s2_data_q;
    s3_addr_d  = s3_addr_q;
    s3_data_d  = s3_data_q;

    vld_d[STAGE_S1] = bus.in_valid;
    vld_d[STAGE_S2] = vld_q[STAGE_S1];
    vld_d[STAGE_S3] = vld_q[STAGE_S2];

    if (bus.in_valid) begin
      s1_addr_d  = bus.in_addr;
      s1_first_d = bus.in_first;
      s1_last_d  = bus.in_last;
      s1_data_d  = bus.in_data;
    end

    if (vld_q[STAGE_S1]) begin
      s2_addr_d = s1_addr_q;
      s2_data_d = sum_c;
    end

    if (vld_q[STAGE_S2]) begin
      s3_addr_d = s2_addr_q;
      s3_data_d = s2_data_q;
    end

    done_d = vld_q[STAGE_S1] & s1_last_q;
    busy_d = |vld_d;
  end

  // Stage registers; reset drops every in-flight row including S3
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q      <= '0;
      s1_addr_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      done_q     <= 1'b0;
      s3_addr_q  <= '0;
      s3_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      s1_addr_q  <= s1_addr_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_data_q  <= s1_data_d;
      s2_addr_q  <= s2_addr_d;
      s2_data_q  <= s2_data_d;
      done_q     <= done_d;
      s3_addr_q  <= s3_addr_d;
      s3_data_q  <= s3_data_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.obuf_write_req  = vld_q[STAGE_S2];
  assign bus.obuf_write_addr = s2_addr_q;
  assign bus.obuf_write_data = s2_data_q;
  assign bus.done_valid      = done_q;
  assign bus.done_addr       = s2_addr_q;
  assign bus.busy            = busy_q;

endmodule
